// File: rtl/odd_pkg.sv
// Shared types and constants for the odd-pipe issue controller.
// Latency: n/a (package only).
// Backpressure: n/a. ODD_ISSUE_FWD_EN selects forward-stage thresholds over register-file writeback.
package odd_pkg;

   // producer unit encoding as delivered by decode
   typedef enum logic [1:0] {
      UNIT_PERM  = 2'd0,
      UNIT_LS    = 2'd1,
      UNIT_BR    = 2'd2,
      UNIT_UNDEF = 2'd3
   } unit_e;

   // cycles from issue until each unit's result is forwardable
   localparam int PERM_LAT_DEF = 4;
   localparam int LS_LAT_DEF   = 6;
   localparam int BR_LAT_DEF   = 1;
   // age at which any result has reached the register file
   localparam int WB_AGE_DEF   = 7;

   // ages 0..7, age 0 being the issue register
   localparam int SB_DEPTH = 8;

`ifdef ODD_ISSUE_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [0:6]  rt_addr;
      unit_e       unit;
   } sb_entry_t;

endpackage

// File: rtl/odd_scoreboard.sv
// 8-entry age scoreboard: shifts one age per cycle and flags RAW hazards on the presented sources.
// Latency: inserted entry is visible at age 0 after one edge; hazard is combinational.
// Backpressure: none inside; the caller withholds insertion while hazard is high.
module odd_scoreboard
   import odd_pkg::*;
#(
   parameter int PERM_LAT = PERM_LAT_DEF,
   parameter int LS_LAT   = LS_LAT_DEF,
   parameter int BR_LAT   = BR_LAT_DEF,
   parameter int WB_AGE   = WB_AGE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  sb_entry_t  i_ins,
   input  logic       i_kill0,
   input  logic [0:6] i_ra,
   input  logic [0:6] i_rb,
   input  logic [0:6] i_rc,
   input  logic [2:0] i_use,
   output sb_entry_t  o_age0,
   output logic       o_hazard
);

   // without forwarding every consumer waits for register-file writeback
   localparam int THR_PERM = FWD_EN ? PERM_LAT : WB_AGE;
   localparam int THR_LS   = FWD_EN ? LS_LAT   : WB_AGE;
   localparam int THR_BR   = FWD_EN ? BR_LAT   : WB_AGE;

   sb_entry_t r_sb [SB_DEPTH];
   logic      w_hazard;

   function automatic int unit_thr(input unit_e u);
      int t;
      case (u)
         UNIT_LS: t = THR_LS;
         UNIT_BR: t = THR_BR;
         default: t = THR_PERM;   // Perm and the undefined encoding
      endcase
      return t;
   endfunction

   // age every entry by one; a flushed issue slot leaves as a bubble so it is never tracked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < SB_DEPTH; a++) r_sb[a] <= '0;
      end else begin
         r_sb[0] <= i_ins;
         r_sb[1] <= r_sb[0];
         if (i_kill0) r_sb[1].valid <= 1'b0;
         for (int a = 2; a < SB_DEPTH; a++) r_sb[a] <= r_sb[a-1];
      end
   end

   // any live writer younger than its unit threshold blocks a used source with the same address
   always_comb begin
      w_hazard = 1'b0;
      for (int a = 0; a < SB_DEPTH; a++) begin
         if (r_sb[a].valid && r_sb[a].reg_write && (a < unit_thr(r_sb[a].unit))) begin
            if ((i_use[2] && (r_sb[a].rt_addr == i_ra)) ||
                (i_use[1] && (r_sb[a].rt_addr == i_rb)) ||
                (i_use[0] && (r_sb[a].rt_addr == i_rc)))
               w_hazard = 1'b1;
         end
      end
   end

   assign o_hazard = w_hazard;
   assign o_age0   = r_sb[0];

endmodule

// File: rtl/odd_issue_ctrl.sv
// In-order odd-pipe issue controller: valid/ready intake, RAW stall via age scoreboard, flush squash.
// Latency: accepted instruction appears on iss_* one cycle later (registered).
// Backpressure: in_ready drops on hazard, flush or reset; ODD_ISSUE_FWD_EN enables forward thresholds.
module odd_issue_ctrl
   import odd_pkg::*;
#(
   parameter int PERM_LAT = PERM_LAT_DEF,
   parameter int LS_LAT   = LS_LAT_DEF,
   parameter int BR_LAT   = BR_LAT_DEF,
   parameter int WB_AGE   = WB_AGE_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [0:10] in_op,
   input  logic [2:0]  in_format,
   input  logic [1:0]  in_unit,
   input  logic [0:6]  in_rt_addr,
   input  logic        in_reg_write,
   input  logic [0:6]  in_ra_addr,
   input  logic [0:6]  in_rb_addr,
   input  logic [0:6]  in_rc_addr,
   input  logic [2:0]  in_src_use,
   input  logic [0:17] in_imm,
   input  logic [7:0]  in_pc,
   input  logic        in_first,
   input  logic        flush,
   output logic        iss_valid,
   output logic [0:10] iss_op,
   output logic [2:0]  iss_format,
   output logic [1:0]  iss_unit,
   output logic [0:6]  iss_rt_addr,
   output logic        iss_reg_write,
   output logic [0:17] iss_imm,
   output logic [7:0]  iss_pc,
   output logic        iss_first,
   output logic [15:0] stall_cnt
);

   logic        w_hazard;
   logic        w_accept;
   sb_entry_t   w_ins;
   sb_entry_t   w_age0;

   logic [0:10] r_op;
   logic [2:0]  r_format;
   logic [0:17] r_imm;
   logic [7:0]  r_pc;
   logic        r_first;
   logic [15:0] r_stall_cnt;

   assign in_ready = ~w_hazard & ~flush & ~reset;
   assign w_accept = in_valid & in_ready;

   // scoreboard insertion: the accepted instruction, or a bubble
   always_comb begin
      w_ins = '0;
      if (w_accept) begin
         w_ins.valid     = 1'b1;
         w_ins.reg_write = in_reg_write;
         w_ins.rt_addr   = in_rt_addr;
         w_ins.unit      = unit_e'(in_unit);
      end
   end

   odd_scoreboard #(
      .PERM_LAT (PERM_LAT),
      .LS_LAT   (LS_LAT),
      .BR_LAT   (BR_LAT),
      .WB_AGE   (WB_AGE)
   ) u_sb (
      .clk      (clk),
      .rst      (reset),
      .i_ins    (w_ins),
      .i_kill0  (flush),
      .i_ra     (in_ra_addr),
      .i_rb     (in_rb_addr),
      .i_rc     (in_rc_addr),
      .i_use    (in_src_use),
      .o_age0   (w_age0),
      .o_hazard (w_hazard)
   );

   // issue-stage payload: captured on accept, zeroed for a bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op     <= '0;
         r_format <= '0;
         r_imm    <= '0;
         r_pc     <= '0;
         r_first  <= 1'b0;
      end else if (w_accept) begin
         r_op     <= in_op;
         r_format <= in_format;
         r_imm    <= in_imm;
         r_pc     <= in_pc;
         r_first  <= in_first;
      end else begin
         r_op     <= '0;
         r_format <= '0;
         r_imm    <= '0;
         r_pc     <= '0;
         r_first  <= 1'b0;
      end
   end

   // count cycles lost to operand hazards; a flush cycle is not a stall
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_stall_cnt <= '0;
      else if (in_valid && w_hazard && !flush && (r_stall_cnt != 16'hFFFF))
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   // the issue-register control fields live at scoreboard age 0
   assign iss_valid     = w_age0.valid;
   assign iss_reg_write = w_age0.valid & w_age0.reg_write;
   assign iss_rt_addr   = w_age0.rt_addr;
   assign iss_unit      = w_age0.unit;
   assign iss_op        = r_op;
   assign iss_format    = r_format;
   assign iss_imm       = r_imm;
   assign iss_pc        = r_pc;
   assign iss_first     = r_first;
   assign stall_cnt     = r_stall_cnt;

endmodule

// File: doc/odd_issue_ctrl.md
# odd_issue_ctrl

In-order issue controller in front of the odd pipe (Permute / LocalStore / Branch). It accepts one decoded odd-pipe instruction per cycle from decode with a valid/ready handshake. An 8-entry age scoreboard tracks in-flight destinations and stalls any instruction whose source operands are not yet forwardable. It drives a registered issue stage into the odd pipe's RF/FWD inputs and squashes the issue stage on a taken branch.

## Interface
Parameters:
- PERM_LAT, 4, cycles from issue until a Permute result is forwardable
- LS_LAT, 6, same for LocalStore
- BR_LAT, 1, same for Branch (link-register write)
- WB_AGE, 7, age at which a result is in the register file

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  controller accepts this cycle; acceptance = in_valid & in_ready
- in_op  in  [0:10]  decoded opcode
- in_format  in  [2:0]  instruction format
- in_unit  in  [1:0]  0 Perm, 1 LS, 2 Br, 3 treated as Perm
- in_rt_addr  in  [0:6]  destination register
- in_reg_write  in  1  instruction writes rt
- in_ra_addr, in_rb_addr, in_rc_addr  in  [0:6] each  source addresses (rc = store data)
- in_src_use  in  [2:0]  bit2 ra, bit1 rb, bit0 rc used
- in_imm  in  [0:17]; in_pc  in  [7:0]; in_first  in  1  passed through
- flush  in  1  taken branch from odd pipe; kill younger instruction
- iss_valid  out  1  issue stage holds a live instruction
- iss_op, iss_format, iss_unit, iss_rt_addr, iss_imm, iss_pc, iss_first  out  same widths as inputs
- iss_reg_write  out  1  equals in_reg_write & iss_valid
- stall_cnt  out  [15:0]  saturating count of hazard-stall cycles

## Operation
- Scoreboard entries age 0..7. Each entry holds valid, reg_write, rt_addr and unit. Age 0 is the issue register.
- Every cycle the entries shift: age k moves to k+1 and age 7 drops. Age 0 loads the accepted instruction, or a bubble (valid=0) when nothing is accepted.
- Threshold per producer unit: Perm PERM_LAT, LS LS_LAT, Br BR_LAT, unit 3 PERM_LAT.
- Hazard: any entry with age a where valid & reg_write & a < threshold, and whose rt_addr equals a used source address (ra, rb or rc per in_src_use).
- in_ready = ~hazard & ~flush & ~reset.
- Stall cycle: in_valid & hazard & ~flush. It increments stall_cnt, which saturates at 0xFFFF.
- Flush: the age-0 entry becomes a bubble on the next edge, so iss_valid is 0 for the killed slot and it is not tracked. The pending input is not accepted that cycle. Older entries are untouched.
- Register 0 gets no special treatment; it is tracked like any other register.
- No WB-port conflict check. Every odd-pipe result retires at a fixed total latency.

## Timing
- Reset: all outputs 0, all scoreboard entries invalid, stall_cnt 0. in_ready is 0 while reset is high.
- Latency: an instruction accepted at cycle c appears on iss_* at c+1 (registered outputs).
- Dependent-instruction stall, with the producer accepted at c and the consumer presented from c+1:
  - Perm: 4 stall cycles, consumer accepted at c+5
  - LS: 6 stall cycles
  - Br: 1 stall cycle
  - With forwarding off: 7 stall cycles
- Decode holds in_* stable while in_valid & ~in_ready.
- Flush and hazard in the same cycle: flush wins and stall_cnt does not increment.
- Reset mid-stream: all in-flight tracking is lost. The pipeline is assumed drained by the same reset.

## Configuration
- ODD_ISSUE_FWD_EN
  - Defined: per-unit thresholds as above; results are used from the forward stages.
  - Undefined: every threshold is WB_AGE. Consumers wait for register-file writeback and the odd pipe's forward inputs may be ignored.

## Structure
- Package odd_pkg holds:
  - unit encoding enum (UNIT_PERM, UNIT_LS, UNIT_BR, UNIT_UNDEF)
  - latency constants
  - sb_entry_t struct {valid, reg_write, rt_addr, unit}
- Sub-module odd_scoreboard contains the 8-entry shift array and the combinational hazard compare. It takes the entry to insert and three source addresses with use bits, and returns hazard. The top level holds the issue register fields, the handshake, flush and stall_cnt.

## Test plan
- Independent stream: 10 back-to-back Perm instructions with distinct rt, no shared sources. Expect in_ready held at 1, iss_valid 1 for 10 consecutive cycles, stall_cnt 0.
- Perm RAW: Perm writes r5, next instruction reads ra=r5. Expect in_ready 0 for 4 cycles, 4 bubbles on iss_valid, stall_cnt 4.
- LS then Br RAW:
  - LS writes r9, consumer reads rc=r9: 6 stall cycles.
  - Br writes r0, consumer reads rb=r0: 1 stall cycle.
- Unused source: producer writes r3, consumer has ra=r3 but in_src_use=3'b000. Expect no stall.
- Flush: instruction X accepted at c. Assert flush at c+1. Expect iss_valid 0 at c+2, X not tracked (a later reader of X's rt does not stall), in_ready 0 at c+1.
- Reset: assert reset during a Perm stall. Expect all outputs 0 immediately, and a first instruction accepted on the cycle after release.
